// File: rtl/fpu_fclass_unit_if.sv
// rtl/fpu_fclass_unit_if.sv - operand/result handshake bundle for the FCLASS unit
interface fpu_fclass_unit_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            i_valid;
    logic            i_ready;
    logic [63:0]     i_frs;
    logic            i_is_dbl;
    logic [RD_W-1:0] i_rd;
    logic            o_valid;
    logic            o_ready;
    logic [RD_W-1:0] o_rd;
    logic [XLEN-1:0] o_res;

    modport master (
        output i_valid, i_frs, i_is_dbl, i_rd, o_ready,
        input  i_ready, o_valid, o_rd, o_res
    );

    modport slave (
        input  i_valid, i_frs, i_is_dbl, i_rd, o_ready,
        output i_ready, o_valid, o_rd, o_res
    );
endinterface

// File: rtl/fpu_fclass_unit.sv
// rtl/fpu_fclass_unit.sv - two-stage pipelined FCLASS.S/FCLASS.D unit
module fpu_fclass_unit #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_flush,
    fpu_fclass_unit_if.slave    bus
);

    logic            w_sign;
    logic            w_exp_all_ones;
    logic            w_exp_zero;
    logic            w_frac_zero;
    logic            w_frac_msb;
    logic            w_nan_unboxed;
    logic            w_s2_adv;
    logic            w_s1_adv;
    logic            w_in_fire;
    logic [9:0]      w_mask;
    logic [XLEN-1:0] w_res;

    logic            r_s1_valid;
    logic [RD_W-1:0] r_s1_rd;
    logic            r_sign;
    logic            r_exp_all_ones;
    logic            r_exp_zero;
    logic            r_frac_zero;
    logic            r_frac_msb;
    logic            r_nan_unboxed;

    logic            r_s2_valid;
    logic [RD_W-1:0] r_s2_rd;
    logic [XLEN-1:0] r_s2_res;

    // Precision-normalised field flags; a single operand must be NaN-boxed in the upper word.
    always_comb begin
        if (bus.i_is_dbl) begin
            w_sign         = bus.i_frs[63];
            w_exp_all_ones = &bus.i_frs[62:52];
            w_exp_zero     = ~|bus.i_frs[62:52];
            w_frac_zero    = ~|bus.i_frs[51:0];
            w_frac_msb     = bus.i_frs[51];
            w_nan_unboxed  = 1'b0;
        end else begin
            w_sign         = bus.i_frs[31];
            w_exp_all_ones = &bus.i_frs[30:23];
            w_exp_zero     = ~|bus.i_frs[30:23];
            w_frac_zero    = ~|bus.i_frs[22:0];
            w_frac_msb     = bus.i_frs[22];
            w_nan_unboxed  = (bus.i_frs[63:32] != 32'hFFFF_FFFF);
        end
    end

    assign w_s2_adv    = !r_s2_valid | bus.o_ready;
    assign w_s1_adv    = r_s1_valid & w_s2_adv;
    assign bus.i_ready = (!r_s1_valid | w_s2_adv) & !i_flush;
    assign w_in_fire   = bus.i_valid & bus.i_ready;

    always_comb begin
        w_mask[0] = r_sign  & r_exp_all_ones & r_frac_zero;
        w_mask[1] = r_sign  & !r_exp_zero & !r_exp_all_ones;
        w_mask[2] = r_sign  & r_exp_zero & !r_frac_zero;
        w_mask[3] = r_sign  & r_exp_zero & r_frac_zero;
        w_mask[4] = !r_sign & r_exp_zero & r_frac_zero;
        w_mask[5] = !r_sign & r_exp_zero & !r_frac_zero;
        w_mask[6] = !r_sign & !r_exp_zero & !r_exp_all_ones;
        w_mask[7] = !r_sign & r_exp_all_ones & r_frac_zero;
        w_mask[8] = r_exp_all_ones & !r_frac_zero & !r_frac_msb;
        w_mask[9] = r_exp_all_ones & !r_frac_zero & r_frac_msb;
        // An unboxed single is the canonical qNaN regardless of its low-word bits.
        if (r_nan_unboxed) begin
            w_mask = 10'b10_0000_0000;
        end
        w_res       = '0;
        w_res[9:0]  = w_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_rd    <= '0;
            r_s2_res   <= '0;
        end else begin
            if (i_flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_s1_valid <= 1'b1;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (i_flush) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end

            if (w_s1_adv) begin
                r_s2_rd  <= r_s1_rd;
                r_s2_res <= w_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_s1_rd        <= bus.i_rd;
            r_sign         <= w_sign;
            r_exp_all_ones <= w_exp_all_ones;
            r_exp_zero     <= w_exp_zero;
            r_frac_zero    <= w_frac_zero;
            r_frac_msb     <= w_frac_msb;
            r_nan_unboxed  <= w_nan_unboxed;
        end
    end

    assign bus.o_valid = r_s2_valid;
    assign bus.o_rd    = r_s2_rd;
    assign bus.o_res   = r_s2_res;

endmodule

// File: tb/tb_fpu_fclass_unit.sv
// tb/tb_fpu_fclass_unit.sv - scoreboarded bench for fpu_fclass_unit
module tb_fpu_fclass_unit;

    logic clk;
    logic rst;
    logic i_flush;

    fpu_fclass_unit_if #(.XLEN(32), .RD_W(5)) bus ();

    fpu_fclass_unit #(.XLEN(32), .RD_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_flush (i_flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
        int          t;
    } sb_t;

    typedef struct {
        logic [63:0] frs;
        logic        dbl;
        logic [31:0] res;
    } vec_t;

    sb_t         sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc_n = 0;
    logic        lat_chk = 1'b1;
    logic        prev_hold = 1'b0;
    logic        prev_kill = 1'b0;
    logic [31:0] prev_res;
    logic [4:0]  prev_rd;

    task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    endtask

    function automatic logic [31:0] model(input logic [63:0] f, input logic dbl);
        logic        s;
        logic [10:0] e;
        logic [10:0] emax;
        logic [51:0] m;
        if (!dbl) begin
            if (f[63:32] != 32'hFFFF_FFFF) return 32'h200;
            s = f[31]; e = {3'b000, f[30:23]}; emax = 11'd255; m = {f[22:0], 29'd0};
        end else begin
            s = f[63]; e = f[62:52]; emax = 11'd2047; m = f[51:0];
        end
        if (e == emax) begin
            if (m == 52'd0) return s ? 32'h001 : 32'h080;
            return m[51] ? 32'h200 : 32'h100;
        end
        if (e == 11'd0) begin
            if (m == 52'd0) return s ? 32'h008 : 32'h010;
            return s ? 32'h004 : 32'h020;
        end
        return s ? 32'h002 : 32'h040;
    endfunction

    task automatic cyc(input logic v, input logic [63:0] frs, input logic dbl, input logic [4:0] rd,
                       input logic [31:0] er, input logic ordy, input logic fl, input logic r,
                       output logic acc);
        sb_t e;
        @(negedge clk);
        bus.i_valid = v; bus.i_frs = frs; bus.i_is_dbl = dbl; bus.i_rd = rd;
        bus.o_ready = ordy; i_flush = fl; rst = r;
        #1;
        cyc_n++;
        acc = 1'b0;
        if (prev_kill) begin
            chk("kill_clears_valid", !bus.o_valid, 64'(bus.o_valid), 64'd0);
        end else if (prev_hold) begin
            chk("stall_hold", bus.o_valid && bus.o_res == prev_res && bus.o_rd == prev_rd,
                {bus.o_rd, bus.o_res}, {prev_rd, prev_res});
        end
        if (!r) begin
            if (bus.o_valid) begin
                chk("onehot", $onehot(bus.o_res[9:0]) && bus.o_res[31:10] == 22'd0, 64'(bus.o_res), 64'd0);
                if (ordy) begin
                    if (sb.size() == 0) begin
                        chk("stale_result", 1'b0, 64'(bus.o_rd), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("res", bus.o_res == e.res, 64'(bus.o_res), 64'(e.res));
                        chk("rd", bus.o_rd == e.rd, 64'(bus.o_rd), 64'(e.rd));
                        if (lat_chk) chk("latency", cyc_n - e.t == 2, 64'(cyc_n - e.t), 64'd2);
                    end
                end
            end
            if (v && bus.i_ready) begin
                acc = 1'b1;
                e.rd = rd; e.res = er; e.t = cyc_n;
                sb.push_back(e);
            end
        end
        prev_hold = bus.o_valid && !ordy;
        prev_res  = bus.o_res;
        prev_rd   = bus.o_rd;
        prev_kill = fl || r;
        if (fl || r) sb.delete();
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cyc(1'b0, 64'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, a);
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 20 && sb.size() != 0; i++)
            cyc(1'b0, 64'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, a);
        chk("drain", sb.size() == 0, 64'(sb.size()), 64'd0);
    endtask

    vec_t        vecs[16];
    logic        acc;
    logic [63:0] f;
    logic        d;
    int          idx;
    logic [63:0] sops[4];

    initial begin
        vecs[0]  = '{64'h3FF0000000000000, 1'b1, 32'h040};
        vecs[1]  = '{64'h8000000000000000, 1'b1, 32'h008};
        vecs[2]  = '{64'h0000000000000001, 1'b1, 32'h020};
        vecs[3]  = '{64'h7FF0000000000001, 1'b1, 32'h100};
        vecs[4]  = '{64'h7FF8000000000000, 1'b1, 32'h200};
        vecs[5]  = '{64'hFFF0000000000000, 1'b1, 32'h001};
        vecs[6]  = '{64'hFFFFFFFF_FF800000, 1'b0, 32'h001};
        vecs[7]  = '{64'hFFFFFFFF_00400000, 1'b0, 32'h020};
        vecs[8]  = '{64'h00000000_3F800000, 1'b0, 32'h200};
        vecs[9]  = '{64'hFFFFFFFF_7FC00000, 1'b0, 32'h200};
        vecs[10] = '{64'hFFFFFFFF_7F800001, 1'b0, 32'h100};
        vecs[11] = '{64'hFFFFFFFF_80000000, 1'b0, 32'h008};
        vecs[12] = '{64'h0000000000000000, 1'b1, 32'h010};
        vecs[13] = '{64'h7FF0000000000000, 1'b1, 32'h080};
        vecs[14] = '{64'h800FFFFFFFFFFFFF, 1'b1, 32'h004};
        vecs[15] = '{64'hFFFFFFFE_7F800001, 1'b0, 32'h200};

        bus.i_valid = 1'b0; bus.i_frs = '0; bus.i_is_dbl = 1'b0; bus.i_rd = '0;
        bus.o_ready = 1'b0; i_flush = 1'b0; rst = 1'b1;

        cyc(1'b0, 64'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b0, 64'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b0, 64'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, acc);
        chk("reset_i_ready", bus.i_ready, 64'(bus.i_ready), 64'd1);
        chk("reset_o_res", bus.o_res == 32'd0 && bus.o_rd == 5'd0, {bus.o_rd, bus.o_res}, 64'd0);

        // Single operations against fixed expectations.
        lat_chk = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, vecs[i].frs, vecs[i].dbl, 5'(i + 5), vecs[i].res, 1'b1, 1'b0, 1'b0, acc);
            chk("vec_accept", acc, 64'(acc), 64'd1);
            drain();
        end

        // Four ops with writeback stalled in cycles 2..5.
        lat_chk = 1'b0;
        sops[0] = 64'h3FF0000000000000; sops[1] = 64'hFFF0000000000000;
        sops[2] = 64'h0000000000000001; sops[3] = 64'h7FF8000000000000;
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            if (idx >= 4 && sb.size() == 0) break;
            cyc(idx < 4, sops[idx & 3], 1'b1, 5'(idx + 1), model(sops[idx & 3], 1'b1),
                !(c >= 2 && c <= 5), 1'b0, 1'b0, acc);
            if (c >= 2 && c <= 5) chk("stall_i_ready_low", !bus.i_ready && idx == 2, 64'(bus.i_ready), 64'd0);
            if (acc) idx++;
        end
        chk("stall_all_done", idx == 4 && sb.size() == 0, 64'(idx), 64'd4);

        // Flush and mid-operation reset with two ops in flight.
        for (int k = 0; k < 2; k++) begin
            lat_chk = 1'b0;
            cyc(1'b1, 64'hBFF0000000000000, 1'b1, 5'd21, 32'h002, 1'b1, 1'b0, 1'b0, acc);
            cyc(1'b1, 64'h0000000000000000, 1'b1, 5'd22, 32'h010, 1'b1, 1'b0, 1'b0, acc);
            if (k == 0) begin
                cyc(1'b1, 64'h7FF0000000000000, 1'b1, 5'd23, 32'h080, 1'b1, 1'b1, 1'b0, acc);
                chk("flush_i_ready", !bus.i_ready && !acc, 64'(bus.i_ready), 64'd0);
            end else begin
                cyc(1'b1, 64'h7FF0000000000000, 1'b1, 5'd23, 32'h080, 1'b0, 1'b0, 1'b1, acc);
            end
            cyc(1'b0, 64'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, acc);
            if (k == 1) chk("rst_o_res", bus.o_res == 32'd0 && bus.o_rd == 5'd0, {bus.o_rd, bus.o_res}, 64'd0);
            lat_chk = 1'b1;
            cyc(1'b1, 64'hFFFFFFFF_3F800000, 1'b0, 5'd24, 32'h040, 1'b1, 1'b0, 1'b0, acc);
            chk("post_kill_accept", acc, 64'(acc), 64'd1);
            drain();
            idle(3);
        end

        // Back-to-back random operands at full throughput.
        lat_chk = 1'b1;
        for (int i = 0; i < 16; i++) begin
            f = {$urandom, $urandom};
            d = 1'b1;
            case ($urandom_range(0, 5))
                0: f[62:52] = 11'h7FF;
                1: f[62:52] = 11'h000;
                2: begin d = 1'b0; f[63:32] = 32'hFFFF_FFFF; f[30:23] = 8'hFF; end
                3: begin d = 1'b0; f[63:32] = 32'hFFFF_FFFF; f[30:23] = 8'h00; end
                4: begin d = 1'b0; if ($urandom_range(0, 3) != 0) f[63:32] = 32'hFFFF_FFFF; end
                default: d = 1'b1;
            endcase
            cyc(1'b1, f, d, 5'(i), model(f, d), 1'b1, 1'b0, 1'b0, acc);
            chk("throughput_accept", acc, 64'(acc), 64'd1);
        end
        drain();
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
